// File: rtl/netflow_record_packer_pkg.sv
// Shared constants, header field positions and FSM state encoding for the
// NetFlow export record packer.
package netflow_pkg;

  localparam logic [15:0] NF_VERSION       = 16'h0005;
  localparam int          NF_RECORD_WIDTH  = 240;
  localparam int          NF_DATA_WIDTH    = 64;
  localparam int          NF_HDR_BEATS     = 2;
  localparam int          NF_BEATS_PER_REC = 4;

  // Header word 0: {version, 8'h00, n, seq}; header word 1: {counters, collisions}
  localparam int HDR0_VER_LSB  = 48;
  localparam int HDR0_N_LSB    = 32;
  localparam int HDR0_SEQ_LSB  = 0;
  localparam int HDR1_CNT_LSB  = 32;
  localparam int HDR1_COLL_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_RD,
    S_LD,
    S_B0,
    S_B1,
    S_B2,
    S_B3
  } state_t;

endpackage

// File: rtl/netflow_record_packer_if.sv
// AXI-Stream bundle carrying export frames from the packer to the sink.
interface netflow_record_packer_if
  import netflow_pkg::*;
#(
  parameter int DW = NF_DATA_WIDTH
);
  logic [DW-1:0]   TDATA;
  logic [DW/8-1:0] TSTRB;
  logic            TVALID;
  logic            TREADY;
  logic            TLAST;

  modport master (output TDATA, output TSTRB, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TSTRB, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/netflow_record_packer_flush_timer.sv
// Idle-time counter for a non-empty FIFO; saturates once the timeout value is
// reached so a stuck partial frame is always eventually flushed.
module netflow_flush_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int            CW    = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge ACLK) begin
    if (ARESET || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);
endmodule

// File: rtl/netflow_record_packer.sv
// Packs 240-bit flow records from the export FIFO into NetFlow-style frames:
// two header beats followed by four 64-bit beats per record.
module netflow_record_packer #(
  parameter int          RECORD_WIDTH   = netflow_pkg::NF_RECORD_WIDTH,
  parameter int          DATA_WIDTH     = netflow_pkg::NF_DATA_WIDTH,
  parameter int          RECS_PER_FRAME = 8,
  parameter int          FLUSH_TIMEOUT  = 1000,
  parameter logic [15:0] NF_VERSION     = netflow_pkg::NF_VERSION,
  parameter logic [31:0] SEQ_INIT       = 32'h0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [RECORD_WIDTH-1:0]       fifo_out_exp,
  input  logic                          fifo_empty_exp,
  input  logic [9:0]                    fifo_level,
  output logic                          fifo_rd_exp_en,
  input  logic [31:0]                   counters,
  input  logic [31:0]                   collision_counter,
  netflow_record_packer_if.master       M_AXIS_EXP_RECORDS,
  output logic [31:0]                   frames_sent
);
  import netflow_pkg::*;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_rd_en;
  logic [7:0]              r_n;
  logic [7:0]              r_rec_cnt;
  logic [31:0]             r_seq;
  logic [31:0]             r_frames;
  logic [31:0]             r_cnt_snap;
  logic [31:0]             r_coll_snap;
  logic [RECORD_WIDTH-1:0] r_rec;

  logic                    w_expired;
  logic                    w_start;
  logic [7:0]              w_n;
  logic                    w_last;
  logic                    w_tvalid;
  logic                    w_tlast;
  logic [DATA_WIDTH-1:0]   w_tdata;
  logic [DATA_WIDTH-1:0]   w_hdr0;
  logic [DATA_WIDTH-1:0]   w_hdr1;
  logic [DATA_WIDTH-1:0]   w_rec_word [NF_BEATS_PER_REC];

  assign w_start = (r_state == S_IDLE) &&
                   ((fifo_level >= 10'(RECS_PER_FRAME)) || ((fifo_level != 10'd0) && w_expired));
  assign w_n     = (fifo_level >= 10'(RECS_PER_FRAME)) ? 8'(RECS_PER_FRAME) : fifo_level[7:0];
  assign w_last  = (r_rec_cnt == (r_n - 8'd1));

  netflow_flush_timer #(
    .TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_timer (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .i_clr     ((fifo_level == 10'd0) || w_start),
    .i_en      (r_state == S_IDLE),
    .o_expired (w_expired)
  );

  // The top record beat carries only 48 payload bits; its upper 16 bits are zero.
  for (genvar gi = 0; gi < NF_BEATS_PER_REC - 1; gi++) begin : g_rec_word
    assign w_rec_word[gi] = r_rec[gi*DATA_WIDTH +: DATA_WIDTH];
  end
  assign w_rec_word[NF_BEATS_PER_REC-1] = {16'h0, r_rec[RECORD_WIDTH-1:(NF_BEATS_PER_REC-1)*DATA_WIDTH]};

  always_comb begin
    w_hdr0 = '0;
    w_hdr1 = '0;
    w_hdr0[HDR0_VER_LSB +: 16]  = NF_VERSION;
    w_hdr0[HDR0_N_LSB +: 8]     = r_n;
    w_hdr0[HDR0_SEQ_LSB +: 32]  = r_seq;
    w_hdr1[HDR1_CNT_LSB +: 32]  = r_cnt_snap;
    w_hdr1[HDR1_COLL_LSB +: 32] = r_coll_snap;
  end

  always_comb begin
    w_state_next = r_state;
    w_tvalid     = 1'b0;
    w_tlast      = 1'b0;
    w_tdata      = '0;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_HDR0;
      S_HDR0: begin
        w_tvalid = 1'b1;
        w_tdata  = w_hdr0;
        if (M_AXIS_EXP_RECORDS.TREADY) w_state_next = S_HDR1;
      end
      S_HDR1: begin
        w_tvalid = 1'b1;
        w_tdata  = w_hdr1;
        if (M_AXIS_EXP_RECORDS.TREADY) w_state_next = S_RD;
      end
      S_RD:   if (r_rd_en) w_state_next = S_LD;
      S_LD:   w_state_next = S_B0;
      S_B0: begin
        w_tvalid = 1'b1;
        w_tdata  = w_rec_word[0];
        if (M_AXIS_EXP_RECORDS.TREADY) w_state_next = S_B1;
      end
      S_B1: begin
        w_tvalid = 1'b1;
        w_tdata  = w_rec_word[1];
        if (M_AXIS_EXP_RECORDS.TREADY) w_state_next = S_B2;
      end
      S_B2: begin
        w_tvalid = 1'b1;
        w_tdata  = w_rec_word[2];
        if (M_AXIS_EXP_RECORDS.TREADY) w_state_next = S_B3;
      end
      S_B3: begin
        w_tvalid = 1'b1;
        w_tlast  = w_last;
        w_tdata  = w_rec_word[3];
        if (M_AXIS_EXP_RECORDS.TREADY) w_state_next = w_last ? S_IDLE : S_RD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_n         <= '0;
      r_rec_cnt   <= '0;
      r_seq       <= SEQ_INIT;
      r_frames    <= '0;
      r_cnt_snap  <= '0;
      r_coll_snap <= '0;
      r_rec       <= '0;
    end else begin
      r_state <= w_state_next;
      // Read strobe is high for the whole RD cycle so data lands during LD.
      r_rd_en <= (w_state_next == S_RD) && !fifo_empty_exp;
      if (w_start) begin
        r_n         <= w_n;
        r_rec_cnt   <= '0;
        r_cnt_snap  <= counters;
        r_coll_snap <= collision_counter;
      end
      if (r_state == S_LD) r_rec <= fifo_out_exp;
      if ((r_state == S_B3) && M_AXIS_EXP_RECORDS.TREADY) begin
        r_rec_cnt <= r_rec_cnt + 8'd1;
        if (w_last) begin
          r_seq    <= r_seq + {24'h0, r_n};
          r_frames <= r_frames + 32'd1;
        end
      end
    end
  end

  assign fifo_rd_exp_en            = r_rd_en;
  assign frames_sent               = r_frames;
  assign M_AXIS_EXP_RECORDS.TDATA  = w_tdata;
  assign M_AXIS_EXP_RECORDS.TSTRB  = {(DATA_WIDTH/8){w_tvalid}};
  assign M_AXIS_EXP_RECORDS.TVALID = w_tvalid;
  assign M_AXIS_EXP_RECORDS.TLAST  = w_tlast;
endmodule

// File: tb/tb_netflow_record_packer.sv
// Directed bench for the NetFlow record packer: full frames, timeout flush,
// back-pressure, mid-frame reset, sequence wrap and the empty/level mismatch.
module tb_netflow_record_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [239:0] fifo_out = '0;
  logic         fifo_empty;
  logic [9:0]   fifo_level;
  logic         rd_en;
  logic [31:0]  counters;
  logic [31:0]  coll;
  logic [31:0]  frames_sent;
  logic         force_empty;
  int           pushed;
  int           popped = 0;

  logic         rd_en2;
  logic [31:0]  frames_sent2;

  bit           rand_ready = 1'b0;
  bit           ready_val  = 1'b1;

  int           n_checks = 0;
  int           n_errors = 0;

  logic [64:0]  beats [$];
  int           bcyc [$];
  int           lasts = 0;
  int           rd_cnt = 0;
  int           cyc = 0;
  logic [63:0]  hdr2_q [$];
  bit           exp_hdr2 = 1'b1;

  netflow_record_packer_if ax ();
  netflow_record_packer_if ax2 ();

  always #5 clk = ~clk;

  netflow_record_packer #(
    .RECS_PER_FRAME (8),
    .FLUSH_TIMEOUT  (1000)
  ) dut (
    .ACLK               (clk),
    .ARESET             (rst),
    .fifo_out_exp       (fifo_out),
    .fifo_empty_exp     (fifo_empty),
    .fifo_level         (fifo_level),
    .fifo_rd_exp_en     (rd_en),
    .counters           (counters),
    .collision_counter  (coll),
    .M_AXIS_EXP_RECORDS (ax),
    .frames_sent        (frames_sent)
  );

  netflow_record_packer #(
    .RECS_PER_FRAME (8),
    .FLUSH_TIMEOUT  (2),
    .SEQ_INIT       (32'hFFFF_FFFE)
  ) dut_wrap (
    .ACLK               (clk),
    .ARESET             (rst),
    .fifo_out_exp       (240'h1234),
    .fifo_empty_exp     (1'b0),
    .fifo_level         (10'd4),
    .fifo_rd_exp_en     (rd_en2),
    .counters           (counters),
    .collision_counter  (coll),
    .M_AXIS_EXP_RECORDS (ax2),
    .frames_sent        (frames_sent2)
  );

  assign ax2.TREADY = 1'b1;

  function automatic logic [239:0] rec_of(input int k);
    logic [239:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) r[i*16 +: 16] = 16'h8000 | 16'(k * 16 + i);
    return r;
  endfunction

  // FIFO model: level is pushed minus popped, data valid the cycle after a read.
  assign fifo_level = 10'(pushed - popped);
  assign fifo_empty = (fifo_level == 10'd0) || force_empty;

  always @(posedge clk) begin
    if (rd_en) begin
      fifo_out <= rec_of(popped);
      popped   <= popped + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    ax.TREADY = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      exp_hdr2   = 1'b1;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", ax.TVALID, 1'b1);
        check("stall_beat", {ax.TLAST, ax.TDATA}, prev_beat);
      end
      if (ax.TVALID && ax.TREADY) begin
        beats.push_back({ax.TLAST, ax.TDATA});
        bcyc.push_back(cyc);
        if (ax.TLAST) lasts++;
      end
      prev_stall = ax.TVALID && !ax.TREADY;
      prev_beat  = {ax.TLAST, ax.TDATA};
      if (rd_en) rd_cnt++;
      if (ax2.TVALID) begin
        if (exp_hdr2 && hdr2_q.size() < 4) hdr2_q.push_back(ax2.TDATA);
        exp_hdr2 = ax2.TLAST;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beats.delete();
    bcyc.delete();
    lasts  = 0;
    rd_cnt = 0;
  endtask

  task automatic wait_last(input int target, input int budget, input string tag);
    int t;
    t = 0;
    while (lasts < target && t < budget) begin
      tick();
      t++;
    end
    if (lasts < target) check({tag, "_timeout"}, lasts, target);
  endtask

  task automatic check_frame(input int base, input int n, input int first,
                             input logic [31:0] seq, input string tag);
    logic [239:0] r;
    logic [64:0]  e;
    int           nb;
    nb = 2 + 4 * n;
    check({tag, "_hdr0"}, beats[base], {1'b0, 16'h0005, 8'h00, 8'(n), seq});
    check({tag, "_hdr1"}, beats[base+1], {1'b0, counters, coll});
    for (int k = 0; k < n; k++) begin
      r = rec_of(first + k);
      for (int b = 0; b < 4; b++) begin
        e[63:0] = (b == 3) ? {16'h0, r[239:192]} : r[b*64 +: 64];
        e[64]   = (2 + 4 * k + b) == (nb - 1);
        check($sformatf("%s_r%0d_b%0d", tag, k, b), beats[base+2+4*k+b], e);
      end
    end
    $display("frame %s: n=%0d seq=%0h first_rec=%0d", tag, n, seq, first);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    pushed      = 0;
    force_empty = 1'b0;
    counters    = 32'h1111_2222;
    coll        = 32'h3333_4444;
    repeat (3) tick();
    check("rst_tvalid", ax.TVALID, 1'b0);
    check("rst_tlast", ax.TLAST, 1'b0);
    check("rst_tdata", ax.TDATA, 64'h0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_frames", frames_sent, 32'h0);
    rst = 1'b0;

    // Full frame of 8 records with TREADY held high.
    tick();
    clear_mon();
    pushed = 8;
    wait_last(1, 200, "t1");
    check("t1_beats", beats.size(), 34);
    check_frame(0, 8, 0, 32'h0, "t1");
    check("t1_rd_pulses", rd_cnt, 8);
    check("t1_cycles", bcyc[33] - bcyc[0], 49);
    tick();
    check("t1_frames", frames_sent, 32'd1);
    check("wrap_count", hdr2_q.size() >= 2, 1'b1);
    check("wrap_hdr_a", hdr2_q[0], 64'h0005_0004_FFFF_FFFE);
    check("wrap_hdr_b", hdr2_q[1], 64'h0005_0004_0000_0002);

    // Three records held: frame only after the flush timeout.
    begin
      int t;
      clear_mon();
      pushed = 11;
      t = 0;
      while (!ax.TVALID && t < 1100) begin
        tick();
        t++;
      end
      check("t2_flush_cycle", t, 1000);
    end
    wait_last(1, 200, "t2");
    check("t2_beats", beats.size(), 14);
    check_frame(0, 3, 8, 32'd8, "t2");
    check("t2_b3_upper", beats[5][63:48], 16'h0);
    tick();

    // Three frames under random back-pressure.
    clear_mon();
    counters   = 32'hDEAD_0001;
    coll       = 32'h0000_BEEF;
    rand_ready = 1'b1;
    pushed     = 35;
    wait_last(3, 3000, "t3");
    rand_ready = 1'b0;
    check("t3_beats", beats.size(), 102);
    check_frame(0, 8, 11, 32'd11, "t3a");
    check_frame(34, 8, 19, 32'd19, "t3b");
    check_frame(68, 8, 27, 32'd27, "t3c");
    check("t3_rd_pulses", rd_cnt, 24);
    tick();
    check("t3_frames", frames_sent, 32'd5);

    // Reset while record 2 is on beat B2.
    clear_mon();
    pushed = 43;
    repeat (19) tick();
    check("t4_position", beats.size(), 13);
    rst = 1'b1;
    tick();
    check("t4_rst_tvalid", ax.TVALID, 1'b0);
    check("t4_rst_rd_en", rd_en, 1'b0);
    check("t4_rst_frames", frames_sent, 32'h0);
    tick();
    clear_mon();
    pushed = 46;
    rst    = 1'b0;
    wait_last(1, 200, "t4");
    check("t4_beats", beats.size(), 34);
    check_frame(0, 8, 38, 32'h0, "t4");
    tick();
    check("t4_frames", frames_sent, 32'd1);

    // Level says one record but the FIFO reports empty.
    begin
      int t;
      clear_mon();
      force_empty = 1'b1;
      pushed      = 47;
      t = 0;
      while (beats.size() < 2 && t < 1200) begin
        tick();
        t++;
      end
      check("t5_hdr_seen", beats.size() >= 2, 1'b1);
      repeat (10) tick();
      check("t5_hold_beats", beats.size(), 2);
      check("t5_hold_tvalid", ax.TVALID, 1'b0);
      check("t5_hold_rd", rd_cnt, 0);
      force_empty = 1'b0;
    end
    wait_last(1, 200, "t5");
    check("t5_beats", beats.size(), 6);
    check_frame(0, 1, 46, 32'd8, "t5");
    tick();
    check("t5_frames", frames_sent, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
